muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and HI/LO width in bits (even, >= 8).
REQ-002 SHALL have parameter: CNT_W, $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port: clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  unit able to accept a request.
REQ-007 SHALL have port: op  input  4  one-hot {MULT, MULTU, DIV, DIVU}.
REQ-008 SHALL have port: src0  input  WIDTH  multiplicand / dividend.
REQ-009 SHALL have port: src1  input  WIDTH  multiplier / divisor.
REQ-010 SHALL have port: flush  input  1  abort in-flight operation (exception or branch kill).
REQ-011 SHALL have port: out_valid  output  1  result on hi/lo valid.
REQ-012 SHALL have port: out_ready  input  1  consumer takes result.
REQ-013 SHALL have port: hi  output  WIDTH  product upper half / remainder.
REQ-014 SHALL have port: lo  output  WIDTH  product lower half / quotient.
REQ-015 SHALL have port: busy  output  1  high in CALC or DONE.

Function
REQ-016 SHALL implement three states: IDLE, CALC, DONE.
REQ-017 in_ready SHALL be 1 exactly when state is IDLE and flush is 0.
REQ-018 Accept SHALL occur on an edge where in_valid and in_ready are both 1 and op is non-zero; IDLE -> CALC, counter loaded with WIDTH, operands latched.
REQ-019 op == 0 SHALL be ignored (no state change); multi-hot op SHALL resolve by priority MULT > MULTU > DIV > DIVU.
REQ-020 Signed ops SHALL iterate on operand magnitudes and apply sign correction on the CALC -> DONE transition.
REQ-021 CALC SHALL perform one bit per cycle (shift-add for multiply, restoring subtract for divide), decrementing the counter; after exactly WIDTH CALC edges, state -> DONE.
REQ-022 out_valid SHALL be 1 exactly in DONE; for accept at edge E0, out_valid first rises after edge E0+WIDTH.
REQ-023 In DONE, hi/lo SHALL be stable until out_valid && out_ready, then state -> IDLE at that edge; no back-to-back overlap.
REQ-024 MULT/MULTU: {hi,lo} SHALL equal the full 2*WIDTH-bit signed/unsigned product.
REQ-025 DIV: lo = quotient truncated toward zero; hi = remainder with dividend's sign.
REQ-026 Divide by zero (DIV or DIVU) SHALL give lo = all ones, hi = src0; no exception raised.
REQ-027 DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0.
REQ-028 flush SHALL force state -> IDLE at the next edge from any state, suppress out_valid for the aborted op, and block acceptance in that cycle.
REQ-029 hi/lo SHALL retain last completed result while IDLE.

Reset
REQ-030 resetn low SHALL immediately force state IDLE, counter 0, hi = 0, lo = 0, out_valid = 0, busy = 0; in_ready = 1 once resetn is high.
REQ-031 resetn asserted mid-CALC SHALL discard the operation; no out_valid follows deassertion.

Structure
REQ-032 Op bit indices (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and op-field width macro SHALL live in the shared defines header alongside the ALU op definitions.
REQ-033 State encodings SHALL be localparams inside muldiv_unit.
REQ-034 One sub-module, div_restore_step (combinational one-bit restoring subtract/shift, WIDTH-parameterised), SHALL be instantiated once.

Verification (WIDTH=32)
REQ-035 MULT src0=FFFFFFFD, src1=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; out_valid exactly 32 cycles after accept.
REQ-036 DIVU 00000064 / 00000007 -> lo=0000000E, hi=00000002; DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 DIVU 00000005 / 0 -> lo=FFFFFFFF, hi=00000005; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
REQ-038 flush on 10th CALC cycle -> no out_valid, in_ready=1 next cycle; following MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-039 out_ready held low 5 cycles in DONE -> hi/lo unchanged, in_ready=0, busy=1; out_ready high -> IDLE next edge.
REQ-040 resetn pulsed low mid-CALC -> all outputs at reset values immediately, no stale out_valid afterward.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op-field layout shared by the multiply/divide unit and its users
package muldiv_unit_pkg;
    localparam int MDU_OP_W  = 4;
    localparam int MDU_MULT  = 3;
    localparam int MDU_MULTU = 2;
    localparam int MDU_DIV   = 1;
    localparam int MDU_DIVU  = 0;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake bundle of the multiply/divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
    import muldiv_unit_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [MDU_OP_W-1:0] op;
    logic [WIDTH-1:0]    src0;
    logic [WIDTH-1:0]    src1;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;
    logic                busy;
    modport slave (input in_valid, op, src0, src1, flush, out_ready, output in_ready, out_valid, hi, lo, busy);
    modport master (output in_valid, op, src0, src1, flush, out_ready, input in_ready, out_valid, hi, lo, busy);
endinterface

// File: rtl/muldiv_unit_div_restore_step.sv
// div_restore_step: one restoring-division iteration, shifting a dividend bit into the partial remainder
module div_restore_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_i};
    assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle signed/unsigned multiply and restoring divide
module muldiv_unit import muldiv_unit_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic           clk,
    input logic           resetn,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem, div_quo, step_acc, step_q;
    logic [2*WIDTH-1:0] prod;
    logic               op_div, sgn, a_neg, b_neg;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (acc_q),
        .quo_i (q_q),
        .div_i (b_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    // MULT > MULTU > DIV > DIVU: a divide is selected only when neither multiply bit is set
    assign op_div = ~bus.op[MDU_MULT] & ~bus.op[MDU_MULTU];
    assign sgn    = bus.op[MDU_MULT] | (op_div & bus.op[MDU_DIV]);
    assign a_neg  = sgn & bus.src0[WIDTH-1];
    assign b_neg  = sgn & bus.src1[WIDTH-1];

    assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
    assign step_acc = is_div_q ? div_rem : mul_sum[WIDTH:1];
    assign step_q   = is_div_q ? div_quo : {mul_sum[0], q_q[WIDTH-1:1]};
    assign prod     = neg_lo_q ? -{step_acc, step_q} : {step_acc, step_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (bus.in_valid && |bus.op) begin
                state_d  = CALC;
                cnt_d    = CNT_W'(WIDTH);
                acc_d    = '0;
                q_d      = a_neg ? -bus.src0 : bus.src0;
                b_d      = b_neg ? -bus.src1 : bus.src1;
                is_div_d = op_div;
                // divide by zero keeps an all-ones quotient regardless of dividend sign
                neg_lo_d = (a_neg ^ b_neg) & ~(op_div & (bus.src1 == '0));
                neg_hi_d = op_div ? a_neg : a_neg ^ b_neg;
            end
        end else if (state_q == CALC) begin
            acc_d = step_acc;
            q_d   = step_q;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = DONE;
                hi_d    = is_div_q ? (neg_hi_q ? -step_acc : step_acc) : prod[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? (neg_lo_q ? -step_q : step_q) : prod[WIDTH-1:0];
            end
        end else begin
            state_d = bus.out_ready ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~bus.flush;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_mode = 0;
    int   m_left = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (o[3]) return 64'(sa * sb);
        if (o[2]) return 64'(ua * ub);
        if (o[1] || o[0]) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o[1]) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            return {r[31:0], q[31:0]};
        end
        return 64'd0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // 0 idle, 1 computing, 2 holding a result
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode <= 0;
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (bus.flush) begin
            m_mode <= 0;
        end else if (m_mode == 0) begin
            if (bus.in_valid && bus.op != 4'd0) begin
                m_mode <= 1;
                m_left <= 32;
                m_res  <= ref_res(bus.op, bus.src0, bus.src1);
            end
        end else if (m_mode == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_mode <= 2;
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
            end
        end else if (bus.out_ready) begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(bus.in_ready), 64'(m_mode == 0 && !bus.flush));
        chk("out_valid", 64'(bus.out_valid), 64'(m_mode == 2));
        chk("busy", 64'(bus.busy), 64'(m_mode != 0));
        chk("hi", 64'(bus.hi), 64'(m_hi));
        chk("lo", 64'(bus.lo), 64'(m_lo));
    end

    task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.src0 = a;
        bus.src1 = b;
        chk("accept_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 4'd0;
    endtask

    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int n;
        start_op(o, a, b);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 100);
        chk({nm, "_latency"}, 64'(n), 64'd32);
        chk({nm, "_result"}, {bus.hi, bus.lo}, exp);
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            chk({nm, "_release"}, 64'(bus.out_valid), 64'd0);
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int r;
        bus.in_valid = 1'b0;
        bus.op = 4'd0;
        bus.src0 = '0;
        bus.src1 = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        chk("model_mult", ref_res(4'b1000, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_divu", ref_res(4'b0001, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        chk("model_div", ref_res(4'b0010, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_divmin", ref_res(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("model_div0", ref_res(4'b0010, 32'hFFFF_FFF0, 32'd0), 64'hFFFF_FFF0_FFFF_FFFF);
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

        run_op("mult", 4'b1000, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("divu", 4'b0001, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E);
        run_op("div", 4'b0010, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 4'b0001, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF);
        run_op("div0", 4'b0010, 32'hFFFF_FFF0, 32'h0000_0000, 64'hFFFF_FFF0_FFFF_FFFF);
        run_op("divmin", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("prio_multu", 4'b0110, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
        run_op("prio_div", 4'b0011, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);

        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("op_zero_ignored", 64'(bus.busy), 64'd0);

        start_op(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        chk("flush_blocks_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        #1;
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        run_op("multu", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        bus.out_ready = 1'b0;
        run_op("bp_divu", 4'b0001, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_busy", 64'(bus.busy), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_retains", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        start_op(4'b1000, 32'hFFFF_FFFD, 32'h0000_0005);
        repeat (8) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);

        repeat (6000) begin
            @(negedge clk);
            #1;
            bus.in_valid = 1'($urandom % 2);
            r = int'($urandom % 10);
            bus.op = (r == 0) ? 4'd0 : (r == 1) ? 4'($urandom % 16) : 4'(1 << ($urandom % 4));
            bus.src0 = rnd_opnd();
            bus.src1 = rnd_opnd();
            bus.flush = ($urandom % 60) == 0;
            bus.out_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
